// File: rtl/vga_sync_decoder.sv
// Purpose: recovers x/y, data-enable and 640x480@60 frame lock from active-low hsync/vsync alone.
// Latency: x/y/locked/timing_err register one clock after the sync sample; de/frame_start decode those registers.
// Backpressure: none; consumes a free-running pixel-rate stream with no flow control.
module vga_sync_decoder #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int H_SYNC_START = 656,
  parameter int V_SYNC_START = 490,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       locked,
  output logic       frame_start,
  output logic       timing_err
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  X_LOAD = 10'(H_SYNC_START + 1);
  localparam logic [9:0]  Y_LOAD = 10'(V_SYNC_START);
  localparam logic [9:0]  M_MAX  = 10'd1023;
  localparam logic [10:0] V_GOOD = 11'(V_TOTAL);
  localparam logic [1:0]  LOCK_N = 2'(LOCK_FRAMES);

  logic        hs_q, vs_q;
  logic        h_edge, v_edge;
  logic [9:0]  h_meas, v_meas;
  logic        bad_frame;
  logic        line_bad, h_sat_hit, frame_good;
  logic [10:0] v_final;
  state_t      state, state_nxt;
  logic [1:0]  good_cnt, good_cnt_nxt;
  logic        err_nxt;

  // A sync edge is a fall after the input has been seen high since reset.
  assign h_edge = ~hsync & hs_q;
  assign v_edge = ~vsync & vs_q;

  // Line length check at each hsync fall, plus runaway detection while waiting for one.
  assign line_bad  = h_edge && (h_meas != H_LAST);
  assign h_sat_hit = ~h_edge && (h_meas == M_MAX - 10'd1);

  // The h_edge coinciding with v_edge belongs to the frame that is ending.
  assign v_final    = {1'b0, v_meas} + {10'd0, h_edge};
  assign frame_good = (v_final == V_GOOD) && !bad_frame && !line_bad;

  // Sync history for falling-edge detection.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      hs_q <= hsync;
      vs_q <= vsync;
    end
  end

  // Free-running x/y, re-phased by sync edges.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else begin
      if (h_edge)           x <= X_LOAD;
      else if (x == H_LAST) x <= '0;
      else                  x <= x + 10'd1;

      if (v_edge)                      y <= Y_LOAD;
      else if (!h_edge && x == H_LAST) y <= (y == V_LAST) ? 10'd0 : y + 10'd1;
    end
  end

  // Line length and per-frame line count measurement.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      h_meas    <= '0;
      v_meas    <= '0;
      bad_frame <= 1'b0;
    end else begin
      if (h_edge)                h_meas <= '0;
      else if (h_meas != M_MAX)  h_meas <= h_meas + 10'd1;

      if (v_edge)                           v_meas <= '0;
      else if (h_edge && v_meas != M_MAX)   v_meas <= v_meas + 10'd1;

      if (v_edge)        bad_frame <= 1'b0;
      else if (line_bad) bad_frame <= 1'b1;
    end
  end

  // Lock FSM state register and error pulse.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state      <= SEARCH;
      good_cnt   <= '0;
      timing_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      good_cnt   <= good_cnt_nxt;
      timing_err <= err_nxt;
    end
  end

  // Lock FSM next-state: count good frames, drop lock on any timing fault.
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    err_nxt      = 1'b0;
    case (state)
      SEARCH: begin
        if (v_edge) begin
          state_nxt    = MEASURE;
          good_cnt_nxt = '0;
        end
      end
      MEASURE: begin
        if (v_edge) begin
          if (frame_good) begin
            good_cnt_nxt = good_cnt + 2'd1;
            if (good_cnt + 2'd1 == LOCK_N) state_nxt = LOCKED;
          end else begin
            good_cnt_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (line_bad || (v_edge && !frame_good) || h_sat_hit) begin
          state_nxt    = MEASURE;
          good_cnt_nxt = '0;
          err_nxt      = 1'b1;
        end
      end
      default: begin
        state_nxt    = SEARCH;
        good_cnt_nxt = '0;
      end
    endcase
  end

  assign locked      = (state == LOCKED);
  assign de          = locked && (x < H_ACT) && (y < V_ACT);
  assign frame_start = locked && (x == 10'd0) && (y == 10'd0);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Purpose: checks vga_sync_decoder against a frame-position/timestamp model under clean and randomized sync streams.
// Latency: outputs compared on the falling edge after each sampled input.
// Backpressure: none; the bench drives one sync sample per clock.
module tb_vga_sync_decoder;

  localparam int H  = 50;
  localparam int HA = 32;
  localparam int HS = 40;
  localparam int HW = 4;
  localparam int V  = 30;
  localparam int VA = 20;
  localparam int VS = 24;
  localparam int VW = 2;
  localparam int F  = H * V;

  logic       clk_25MHz = 1'b0;
  logic       reset = 1'b1;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [9:0] x, y;
  logic       de, locked, frame_start, timing_err;

  int n_cmp = 0;
  int n_bad = 0;
  int de_cnt, fs_cnt, terr_cnt;

  // generator state
  int gx = 0, gy = 0, line_len = H, frame_lines = V, hs_force = 0;
  bit rand_mode = 1'b0;

  // reference model state: linear frame position plus edge timestamps
  bit m_phs = 1'b0, m_pvs = 1'b0, m_err = 1'b0;
  int m_cyc = 0, m_pos = 0, m_last_h = -1, m_hcnt = 0, m_mode = 0, m_goods = 0;
  bit m_fbad = 1'b0;

  vga_sync_decoder #(
    .H_TOTAL(H), .V_TOTAL(V), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_SYNC_START(HS), .V_SYNC_START(VS), .LOCK_FRAMES(2)
  ) dut (
    .clk_25MHz(clk_25MHz), .reset(reset), .hsync(hsync), .vsync(vsync),
    .x(x), .y(y), .de(de), .locked(locked),
    .frame_start(frame_start), .timing_err(timing_err)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  initial begin
    #(64'd20_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Predict the effect of the next rising edge from the inputs currently driven.
  task automatic model_step();
    bit he, ve, lbad, sat, fgood, err;
    int gap;
    if (reset) begin
      m_phs = 0; m_pvs = 0; m_err = 0; m_cyc = 0; m_pos = 0; m_last_h = -1;
      m_hcnt = 0; m_fbad = 0; m_mode = 0; m_goods = 0;
      return;
    end
    he = m_phs && !hsync;
    ve = m_pvs && !vsync;
    m_phs = hsync;
    m_pvs = vsync;
    lbad = 0; sat = 0; fgood = 0; err = 0;
    gap = m_cyc - m_last_h;
    if (he) begin
      lbad = (gap != H);
      m_last_h = m_cyc;
      m_hcnt++;
      if (lbad) m_fbad = 1;
    end else begin
      sat = (gap == 1023);
    end
    if (ve) begin
      fgood = (m_hcnt == V) && !m_fbad;
      m_hcnt = 0;
      m_fbad = 0;
    end
    if (ve)      m_pos = VS * H + (he ? HS + 1 : (m_pos % H + 1) % H);
    else if (he) m_pos = (m_pos / H) * H + HS + 1;
    else         m_pos = (m_pos + 1) % F;
    if (m_mode == 0) begin
      if (ve) begin m_mode = 1; m_goods = 0; end
    end else if (m_mode == 1) begin
      if (ve) begin
        if (fgood) begin
          m_goods++;
          if (m_goods == 2) m_mode = 2;
        end else m_goods = 0;
      end
    end else begin
      if (lbad || (ve && !fgood) || sat) begin m_mode = 1; m_goods = 0; err = 1; end
    end
    m_err = err;
    m_cyc++;
  endtask

  // One clock: model the edge, then compare every output on the falling edge.
  task automatic cycle();
    int ex, ey;
    bit el, ede, efs;
    model_step();
    @(negedge clk_25MHz);
    ex  = m_pos % H;
    ey  = m_pos / H;
    el  = (m_mode == 2);
    ede = el && ex < HA && ey < VA;
    efs = el && m_pos == 0;
    chk("model_cycle", {8'd0, x, y, de, locked, frame_start, timing_err},
        {8'd0, 10'(ex), 10'(ey), ede, el, efs, m_err});
    if (de) de_cnt++;
    if (frame_start) fs_cnt++;
    if (timing_err) terr_cnt++;
  endtask

  task automatic gen_apply();
    hsync = (hs_force > 0) ? 1'b1 : !(gx >= HS && gx < HS + HW);
    vsync = !(gy >= VS && gy < VS + VW);
    if (rand_mode && $urandom_range(0, 2999) == 0) vsync = ~vsync;
    if (hs_force > 0) hs_force--;
    else if (rand_mode && $urandom_range(0, 1999) == 0) hs_force = $urandom_range(50, 1200);
    gx++;
    if (gx >= line_len) begin
      gx = 0;
      line_len = (rand_mode && $urandom_range(0, 7) == 0) ? $urandom_range(H - 3, H + 3) : H;
      gy++;
      if (gy >= frame_lines) begin
        gy = 0;
        frame_lines = (rand_mode && $urandom_range(0, 3) == 0) ? $urandom_range(V - 2, V + 2) : V;
      end
    end
  endtask

  task automatic step();
    gen_apply();
    cycle();
  endtask

  // Run until the generator is about to drive (tx,ty); bounded.
  task automatic run_to(input int tx, input int ty);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(gx == tx && gy == ty) && n < 4 * F);
    if (n >= 4 * F) begin
      n_bad++;
      $display("FAIL run_to_timeout: got %0d,%0d expected %0d,%0d", gx, gy, tx, ty);
    end
  endtask

  initial begin
    de_cnt = 0; fs_cnt = 0; terr_cnt = 0;
    repeat (3) cycle();
    chk("reset_state", {26'd0, x == 10'd0, y == 10'd0, de, locked, frame_start, timing_err},
        {26'd0, 1'b1, 1'b1, 4'b0000});
    reset = 1'b0;

    // Clean stream: third vsync fall (sample 2F + VS*H) brings lock one clock later.
    repeat (2 * F + VS * H) step();
    chk("lock_not_yet", {31'd0, locked}, 32'd0);
    step();
    chk("lock_after_3rd_vedge", {31'd0, locked}, 32'd1);

    // One locked frame: x/y track the generator, de and frame_start counts.
    run_to(0, 0);
    de_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < F; i++) begin
      step();
      if (i % 97 == 0) chk("align_xy", {12'd0, x, y}, {12'd0, 10'(gx), 10'(gy)});
    end
    chk("de_count", de_cnt, HA * VA);
    chk("fs_count", fs_cnt, 1);

    // One line a clock short while locked.
    terr_cnt = 0;
    line_len = H - 1;
    run_to(0, 0);
    chk("short_line_err", terr_cnt, 1);
    chk("short_line_unlock", {31'd0, locked}, 32'd0);
    run_to(0, 0);
    run_to(0, VS);
    chk("relock_not_yet", {31'd0, locked}, 32'd0);
    step();
    chk("relock_two_frames", {31'd0, locked}, 32'd1);

    // hsync stuck high while locked.
    run_to(0, 0);
    terr_cnt = 0;
    hs_force = 1100;
    repeat (1100) step();
    chk("hsat_err", terr_cnt, 1);
    chk("hsat_unlock", {31'd0, locked}, 32'd0);

    // A 29-line frame during MEASURE delays lock by one frame, with no error pulse.
    run_to(0, 0);
    terr_cnt = 0;
    frame_lines = V - 1;
    run_to(1, VS);
    run_to(1, VS);
    chk("short_frame_g2", {31'd0, locked}, 32'd0);
    run_to(1, VS);
    chk("short_frame_g3", {31'd0, locked}, 32'd0);
    run_to(1, VS);
    chk("short_frame_lock", {31'd0, locked}, 32'd1);
    chk("short_frame_noerr", terr_cnt, 0);

    // Randomized timing faults and glitches.
    rand_mode = 1'b1;
    repeat (15000) step();
    rand_mode = 1'b0;
    hs_force = 0;
    run_to(0, 0);
    repeat (4 * F) step();
    chk("random_recover_lock", {31'd0, locked}, 32'd1);

    // Asynchronous reset mid-frame with hsync held low across release.
    run_to(10, 5);
    #5;
    reset = 1'b1;
    hsync = 1'b0;
    #1;
    chk("async_reset_clear", {28'd0, x == 10'd0, y == 10'd0, locked, de}, {28'd0, 1'b1, 1'b1, 2'b00});
    repeat (3) cycle();
    reset = 1'b0;
    repeat (5) cycle();
    chk("no_hedge_low_release", {12'd0, x, y}, {12'd0, 10'd5, 10'd0});
    run_to(1, VS);
    chk("post_reset_search", {31'd0, locked}, 32'd0);
    run_to(1, VS);
    chk("post_reset_measure", {31'd0, locked}, 32'd0);
    run_to(1, VS);
    chk("post_reset_relock", {31'd0, locked}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receiving end of the VGA timing interface: consumes hsync/vsync produced by the sync generator (horizontal/vertical counters) and recovers pixel coordinates, data-enable and frame lock.
- Used by the frame-capture and on-chip timing-checker paths to regenerate x/y from sync alone. It also flags any deviation from nominal 640x480@60 timing.

Parameters:
- H_TOTAL, 800, clocks per line
- V_TOTAL, 525, lines per frame
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- H_SYNC_START, 656, horizontal count at which hsync first goes low
- V_SYNC_START, 490, vertical count at which vsync first goes low
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..3)

Ports:
- clk_25MHz  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- hsync  in  1  active-low, synchronous to clk_25MHz
- vsync  in  1  active-low, synchronous to clk_25MHz
- x  out  10  recovered horizontal count
- y  out  10  recovered vertical count
- de  out  1  data enable
- locked  out  1  timing lock indicator
- frame_start  out  1  one-cycle pulse at x=0, y=0 while locked
- timing_err  out  1  one-cycle pulse on loss of lock

Behaviour:
- Reset values:
  - x, y, h_meas, v_meas, good_cnt = 0
  - hs_q, vs_q = 0, so no edge can fire until the input has been seen high
  - state = SEARCH
  - locked, timing_err, frame_start, de = 0
- Edge detection:
  - h_edge = (hsync==0 && hs_q==1); v_edge likewise on vsync/vs_q.
  - hs_q and vs_q register the inputs every clock.
- x:
  - On h_edge, load H_SYNC_START+1.
  - Otherwise increment, wrapping H_TOTAL-1 -> 0.
- y:
  - On v_edge, load V_SYNC_START. v_edge wins over a simultaneous wrap.
  - Otherwise, when x wraps to 0, increment, wrapping V_TOTAL-1 -> 0.
  - Otherwise hold.
- h_meas:
  - Cleared on h_edge, otherwise increments, saturating at 1023.
  - Line good iff h_meas == H_TOTAL-1 at h_edge.
  - Any bad line sets bad_frame.
- v_meas:
  - Counts h_edges. An h_edge in the same cycle as v_edge counts toward the ending frame.
  - On v_edge, frame good iff final count == V_TOTAL and bad_frame == 0.
  - On v_edge, v_meas and bad_frame clear.
- FSM:
  - SEARCH: on first v_edge -> MEASURE, good_cnt = 0.
  - MEASURE: on each v_edge:
    - Good frame: good_cnt+1. If this reaches LOCK_FRAMES -> LOCKED.
    - Bad frame: good_cnt = 0, stay in MEASURE.
  - LOCKED: any of the following -> MEASURE, good_cnt = 0, timing_err = 1 for one cycle:
    - bad line at h_edge
    - bad frame at v_edge
    - h_meas reaching 1023
- locked:
  - Registered; equals (state == LOCKED).
  - Rises on the clock after the qualifying v_edge and falls on the clock after the error event.
- de = locked && x < H_ACTIVE && y < V_ACTIVE. Decoded from registered state, no added latency.
- frame_start = locked && x==0 && y==0.
- Unlocked: x and y keep free-running per the rules above; de and frame_start are forced 0.
- Simultaneous bad line and v_edge in LOCKED: produce a single timing_err pulse, and the frame counts as bad.
- Reset mid-operation: all outputs clear immediately (asynchronous). Relock requires the full SEARCH sequence.

Test Plan:
- Clean 800x525 generator stream, LOCK_FRAMES=2:
  - locked=1 the cycle after the 3rd v_edge.
  - Thereafter x/y equal the generator counts every cycle.
- Locked frame: de high for exactly 307200 cycles; frame_start pulses once per 420000 cycles.
- One 799-clock line while locked:
  - timing_err pulses at that h_edge; locked=0 on the next clock.
  - Relock after 2 further clean frames.
- hsync held high 1100 clocks while locked: timing_err pulse when h_meas hits 1023; locked drops.
- Frame with 524 lines during MEASURE: good_cnt returns to 0, lock is delayed by one frame, no timing_err.
- reset asserted mid-frame while locked:
  - x, y, locked, de = 0 immediately.
  - hsync held low across the release produces no h_edge until hsync has been seen high.
